// File: rtl/exp6_controle_exibicao.sv
// Plays the stored colour sequence on the LEDs: each ROM word lit T_ACESO cycles, then dark T_APAGADO cycles.
// Addresses 0..limite (captured at start); signals completion with a one-cycle fim_exibicao pulse.
module exp6_controle_exibicao #(
  parameter int T_ACESO   = 1000,
  parameter int T_APAGADO = 500,
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic              cancelar,
  input  logic [ADDR_W-1:0] limite,
  input  logic [DATA_W-1:0] dado_rom,
  output logic [ADDR_W-1:0] endereco,
  output logic [DATA_W-1:0] leds,
  output logic              exibindo,
  output logic              fim_exibicao,
  output logic [3:0]        db_estado
);

  localparam int TMAX = (T_ACESO > T_APAGADO) ? T_ACESO : T_APAGADO;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] ACESO_FIM   = TW'(T_ACESO - 1);
  localparam logic [TW-1:0] APAGADO_FIM = TW'(T_APAGADO - 1);

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    ACENDE  = 3'd1,
    APAGA   = 3'd2,
    CARREGA = 3'd3,
    FIM     = 3'd4
  } estado_t;

  estado_t           estado_q, estado_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [ADDR_W-1:0] endereco_q, endereco_d;
  logic [ADDR_W-1:0] lim_q, lim_d;
  logic [DATA_W-1:0] leds_q, leds_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q   <= OCIOSO;
      timer_q    <= '0;
      endereco_q <= '0;
      lim_q      <= '0;
      leds_q     <= '0;
    end else begin
      estado_q   <= estado_d;
      timer_q    <= timer_d;
      endereco_q <= endereco_d;
      lim_q      <= lim_d;
      leds_q     <= leds_d;
    end
  end

  always_comb begin
    estado_d   = estado_q;
    timer_d    = timer_q;
    endereco_d = endereco_q;
    lim_d      = lim_q;
    leds_d     = leds_q;

    case (estado_q)
      OCIOSO: begin
        endereco_d = '0;
        leds_d     = '0;
        timer_d    = '0;
        if (iniciar) begin
          lim_d    = limite;
          leds_d   = dado_rom;
          estado_d = ACENDE;
        end
      end
      ACENDE: begin
        if (timer_q == ACESO_FIM) begin
          leds_d   = '0;
          timer_d  = '0;
          estado_d = APAGA;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      APAGA: begin
        if (timer_q == APAGADO_FIM) begin
          timer_d = '0;
          if (endereco_q == lim_q) begin
            estado_d = FIM;
          end else begin
            endereco_d = endereco_q + 1'b1;
            estado_d   = CARREGA;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      CARREGA: begin
        // Address moved last cycle, so the ROM word is now valid.
        leds_d   = dado_rom;
        estado_d = ACENDE;
      end
      FIM: begin
        endereco_d = '0;
        leds_d     = '0;
        estado_d   = OCIOSO;
      end
      default: begin
        endereco_d = '0;
        leds_d     = '0;
        timer_d    = '0;
        estado_d   = OCIOSO;
      end
    endcase

    // Abort takes priority over any timer-driven transition.
    if (cancelar && (estado_q != OCIOSO)) begin
      estado_d   = OCIOSO;
      endereco_d = '0;
      leds_d     = '0;
      timer_d    = '0;
    end
  end

  always_comb begin
    case (estado_q)
      OCIOSO:  db_estado = 4'd0;
      ACENDE:  db_estado = 4'd1;
      APAGA:   db_estado = 4'd2;
      CARREGA: db_estado = 4'd3;
      FIM:     db_estado = 4'd4;
      default: db_estado = 4'hF;
    endcase
  end

  assign endereco     = endereco_q;
  assign leds         = leds_q;
  assign exibindo     = (estado_q != OCIOSO);
  assign fim_exibicao = (estado_q == FIM);

endmodule

// File: tb/tb_exp6_controle_exibicao.sv
// Bench for exp6_controle_exibicao: schedule-based reference model checked every cycle,
// directed scenarios with hand-computed expectations, then randomized start/cancel/limit traffic.
module tb_exp6_controle_exibicao;

  localparam int TA = 3;
  localparam int TB = 2;
  localparam int P  = TA + TB;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       iniciar = 1'b0;
  logic       cancelar = 1'b0;
  logic [3:0] limite = 4'd0;
  logic [3:0] dado_rom;
  logic [3:0] endereco;
  logic [3:0] leds;
  logic       exibindo;
  logic       fim_exibicao;
  logic [3:0] db_estado;

  logic [3:0] rom [16];

  int n_vec = 0;
  int n_err = 0;

  // Reference model: playback is active, m_k = cycles since the start edge, m_lim = captured limit.
  bit ativo = 1'b0;
  int m_k   = 0;
  int m_lim = 0;

  exp6_controle_exibicao #(
    .T_ACESO(TA), .T_APAGADO(TB), .ADDR_W(4), .DATA_W(4)
  ) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .cancelar(cancelar),
    .limite(limite), .dado_rom(dado_rom), .endereco(endereco), .leds(leds),
    .exibindo(exibindo), .fim_exibicao(fim_exibicao), .db_estado(db_estado)
  );

  assign dado_rom = rom[endereco];

  always #5 clock = ~clock;

  function automatic int fim_off(input int lim);
    return (lim + 1) * P + lim + 1;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      ativo <= 1'b0;
      m_k   <= 0;
    end else if (!ativo) begin
      if (iniciar) begin
        ativo <= 1'b1;
        m_k   <= 1;
        m_lim <= int'(limite);
      end
    end else if (cancelar || (m_k == fim_off(m_lim))) begin
      ativo <= 1'b0;
    end else begin
      m_k <= m_k + 1;
    end
  end

  // Expected outputs derived from the position inside the playback schedule.
  always @(negedge clock) begin
    int e_adr, e_led, e_db, e_exi, e_fim, i, r, j, m;
    e_adr = 0; e_led = 0; e_db = 0; e_exi = 0; e_fim = 0;
    if (!reset && ativo) begin
      e_exi = 1;
      if (m_k == fim_off(m_lim)) begin
        e_db = 4; e_adr = m_lim; e_fim = 1;
      end else begin
        if (m_k <= P) begin
          i = 0; r = 1; j = m_k - 1;
        end else begin
          m = m_k - P - 1;
          i = 1 + m / (P + 1);
          r = m % (P + 1);
          j = r - 1;
        end
        e_adr = i;
        if (r == 0)       e_db = 3;
        else if (j < TA) begin e_db = 1; e_led = int'(rom[i]); end
        else              e_db = 2;
      end
    end
    chk("endereco", int'(endereco), e_adr);
    chk("leds", int'(leds), e_led);
    chk("db_estado", int'(db_estado), e_db);
    chk("exibindo", int'(exibindo), e_exi);
    chk("fim_exibicao", int'(fim_exibicao), e_fim);
  end

  // Starts a playback and returns the cycle (1 = first cycle after the start edge) with fim high.
  task automatic play(input logic [3:0] lim, input bit poke, output int fim_cyc,
                      output logic [3:0] led_c2, output int fim_cnt);
    fim_cyc = -1;
    fim_cnt = 0;
    led_c2  = 4'hx;
    limite  = lim;
    iniciar = 1'b1;
    @(posedge clock); #1;
    iniciar = 1'b0;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clock);
      if (c == 2) led_c2 = leds;
      if (poke && c == 3) begin iniciar = 1'b1; limite = 4'd5; end
      if (poke && c == 4) iniciar = 1'b0;
      if (fim_exibicao) begin
        fim_cnt++;
        if (fim_cyc < 0) fim_cyc = c;
      end
      if (fim_cyc > 0 && c > fim_cyc + 3) break;
    end
  endtask

  initial begin
    int fc, cnt;
    logic [3:0] l2;
    for (int i = 0; i < 16; i++) rom[i] = 4'd0;
    rom[0] = 4'b0001; rom[1] = 4'b0010; rom[2] = 4'b0100;

    #1 reset = 1'b1;
    #1;
    chk("rst_endereco", int'(endereco), 0);
    chk("rst_leds", int'(leds), 0);
    chk("rst_db_estado", int'(db_estado), 0);
    chk("rst_exibindo", int'(exibindo), 0);
    chk("rst_fim", int'(fim_exibicao), 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;

    // Single item
    play(4'd0, 1'b0, fc, l2, cnt);
    chk("single_fim_cycle", fc, 6);
    chk("single_led_c2", int'(l2), 1);
    chk("single_fim_count", cnt, 1);

    // Three items
    play(4'd2, 1'b0, fc, l2, cnt);
    chk("three_fim_cycle", fc, 18);

    // Captured limit: iniciar/limite changes during playback are ignored
    play(4'd1, 1'b1, fc, l2, cnt);
    chk("captured_fim_cycle", fc, 12);
    chk("captured_fim_count", cnt, 1);
    repeat (3) @(negedge clock);
    chk("captured_no_restart", int'(exibindo), 0);
    @(posedge clock); #1;

    // Cancel in second cycle of acende
    limite = 4'd2; iniciar = 1'b1;
    @(posedge clock); #1;
    iniciar = 1'b0;
    @(posedge clock); #1;
    cancelar = 1'b1;
    @(posedge clock); #1;
    cancelar = 1'b0;
    chk("cancel_db_estado", int'(db_estado), 0);
    chk("cancel_leds", int'(leds), 0);
    chk("cancel_endereco", int'(endereco), 0);
    chk("cancel_exibindo", int'(exibindo), 0);
    cnt = 0;
    repeat (30) begin @(negedge clock); if (fim_exibicao) cnt++; end
    chk("cancel_no_fim", cnt, 0);

    // Async reset mid-apaga
    limite = 4'd0; iniciar = 1'b1;
    @(posedge clock); #1;
    iniciar = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock); #1;
    chk("pre_reset_apaga", int'(db_estado), 2);
    reset = 1'b1;
    #1;
    chk("areset_db_estado", int'(db_estado), 0);
    chk("areset_leds", int'(leds), 0);
    chk("areset_exibindo", int'(exibindo), 0);
    chk("areset_endereco", int'(endereco), 0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    play(4'd1, 1'b0, fc, l2, cnt);
    chk("after_reset_fim_cycle", fc, 12);
    chk("after_reset_led_c2", int'(l2), 1);

    // Full range, ROM[i] = i
    for (int i = 0; i < 16; i++) rom[i] = 4'(i);
    play(4'd15, 1'b0, fc, l2, cnt);
    chk("full_fim_cycle", fc, 96);

    // Randomized traffic
    for (int i = 0; i < 16; i++) rom[i] = 4'($urandom_range(0, 15));
    for (int c = 0; c < 3000; c++) begin
      @(posedge clock); #1;
      iniciar  = ($urandom_range(0, 7) == 0);
      cancelar = ($urandom_range(0, 99) == 0);
      limite   = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
    end
    iniciar = 1'b0; cancelar = 1'b0;
    repeat (4) @(posedge clock);
    @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/exp6_controle_exibicao.md
Name: exp6_controle_exibicao

Overview:
- Sequencer that plays the stored colour sequence back to the player before each round of the memory game.
- Steps the sequence ROM address from 0 to a captured limit. Drives each ROM word onto the LEDs for a fixed on-time, then blanks them for a fixed off-time.
- Signals completion to the main game control unit, which starts play on completion.
- Sits between the main control unit (start/cancel/done handshake) and the datapath ROM and LED outputs.

Parameters:
- T_ACESO, 1000, clock cycles each item is lit (>= 1).
- T_APAGADO, 500, clock cycles of blank gap after each item (>= 1).
- ADDR_W, 4, ROM address width and limit width.
- DATA_W, 4, ROM word width and LED width.

Ports:
- clock, input, 1, system clock; all state changes on rising edge.
- reset, input, 1, asynchronous, active-high; forces the idle state.
- iniciar, input, 1, start request; sampled only in `ocioso`.
- cancelar, input, 1, synchronous abort; valid in any non-idle state.
- limite, input, ADDR_W, index of last item to show; captured on start.
- dado_rom, input, DATA_W, combinational ROM read data for `endereco`.
- endereco, output, ADDR_W, registered ROM address.
- leds, output, DATA_W, registered LED drive.
- exibindo, output, 1, high whenever state is not `ocioso`.
- fim_exibicao, output, 1, one-cycle pulse in state `fim`.
- db_estado, output, 4, debug state code.

Behaviour:
- Interface: reset is `reset`, asynchronous, active-high; clock is `clock`.
- Reset values: state `ocioso`, endereco=0, leds=0, timer=0, lim_reg=0, exibindo=0, fim_exibicao=0, db_estado=0.
- Timer width is clog2(max(T_ACESO, T_APAGADO)).

States (db_estado code in brackets):
- ocioso [0]: endereco=0, leds=0.
  - If iniciar=1: lim_reg<=limite, timer<=0, leds<=dado_rom (word at address 0), go to `acende`.
  - Otherwise stay.
- acende [1]: leds hold the item.
  - timer counts up.
  - When timer==T_ACESO-1: leds<=0, timer<=0, go to `apaga`.
- apaga [2]: leds=0.
  - When timer==T_APAGADO-1: timer<=0.
  - If endereco==lim_reg, go to `fim`.
  - Otherwise endereco<=endereco+1 and go to `carrega`.
- carrega [3]: one cycle for ROM data to settle at the new address.
  - leds<=dado_rom, go to `acende`.
- fim [4]: fim_exibicao=1 for exactly one cycle, endereco holds lim_reg, then go to `ocioso`.
- Unreachable encodings: db_estado=F, next state `ocioso`.

Timing:
- Each item is lit exactly T_ACESO cycles and dark exactly T_APAGADO cycles.
- Cycles from leaving `ocioso` to entering `fim`: (L+1)*(T_ACESO+T_APAGADO)+L, with L=lim_reg.

Boundary and concurrency rules:
- iniciar while not in `ocioso`: ignored.
- Changes on limite after capture: no effect.
- cancelar=1 in any non-idle state: next edge goes to `ocioso` with leds=0, endereco=0, timer=0, and no fim_exibicao pulse. cancelar wins over every timer transition in the same cycle.
- limite = 2^ADDR_W-1: plays all entries; the address never wraps to 0 before `fim`.
- limite=0: single item, no `carrega` visit.
- Reset asserted mid-operation: immediate asynchronous return to reset values; no pulse.
- iniciar held high continuously: after `fim` and one cycle in `ocioso`, a new playback starts.

Test Plan (T_ACESO=3, T_APAGADO=2):
- Single item: limite=0, ROM[0]=0001, iniciar pulse at edge 0.
  - leds=0001 for cycles 1-3, 0 for cycles 4-5.
  - fim_exibicao=1 only in cycle 6; exibindo=1 in cycles 1-6.
- Three items: limite=2, ROM={0001,0010,0100}.
  - leds show 0001, 0010, 0100, each for 3 cycles, separated by 2 dark cycles plus 1 `carrega` cycle.
  - endereco steps 0→1→2; fim pulse after 17 cycles.
- Captured limit: iniciar pulses and limite changes to 5 during playback of limite=1.
  - Exactly 2 items shown; no restart.
- Cancel: cancelar=1 in 2nd cycle of `acende`.
  - Next cycle: db_estado=0, leds=0, endereco=0, exibindo=0; fim_exibicao never asserted.
- Async reset: reset asserted mid-`apaga` between clock edges.
  - All outputs reach reset values before the next edge; a new iniciar restarts from address 0.
- Full range: limite=15, ROM[i]=i.
  - 16 items shown with endereco 0..15, no wrap.
  - fim after 16*5+15=95 cycles; db_estado follows 0,1,2,3,...,4,0.
